gpu_pixel_arbiter: RTL and testbench
====================================

# gpu_pixel_arbiter

Parametrised pixel output stage for the GPU. It merges the pixel streams of `NUM_SRC` drawing engines (line, fill, and future circle/quad engines) into one buffered stream toward the memory controller. Each pixel carries its colour, and off-screen pixels can be clipped. It replaces the unbuffered line/fill output mux, which had no colour pairing and no backpressure. Arbitration is round-robin, and a grant is held for a whole primitive, so primitives never interleave in the output stream.

## Interface
Clocking and reset: one clock; reset is asynchronous and active-low (`clk`, `n_rst`).

Parameters:
- `NUM_SRC`, 2: number of drawing engines; must be ≥1.
- `DEPTH`, 8: output FIFO entries; must be a power of 2 and ≥2.
- `X_BITS`, 10: x coordinate width.
- `Y_BITS`, 9: y coordinate width.
- `CH_BITS`, 8: bits per colour channel.
- `SCREEN_W`, 640: x clip limit; x ≥ `SCREEN_W` is off-screen.
- `SCREEN_H`, 480: y clip limit; y ≥ `SCREEN_H` is off-screen.

Ports:
- `clk` in 1: system clock.
- `n_rst` in 1: async active-low reset.
- `src_valid_i` in `NUM_SRC`: per-engine pixel valid.
- `src_ready_o` out `NUM_SRC`: per-engine accept.
- `src_last_i` in `NUM_SRC`: marks the final pixel of a primitive.
- `src_x_i` in `NUM_SRC*X_BITS`: packed x; engine k occupies slice k.
- `src_y_i` in `NUM_SRC*Y_BITS`: packed y.
- `src_rgb_i` in `NUM_SRC*3*CH_BITS`: packed colour, ordered {r,g,b} per engine.
- `pix_valid_o` out 1: output pixel valid.
- `pix_ready_i` in 1: downstream accept.
- `x_o` out `X_BITS`, `y_o` out `Y_BITS`: output pixel coordinates.
- `r_o`, `g_o`, `b_o` out `CH_BITS`: output pixel colour.
- `last_o` out 1: last pixel of a primitive.
- `busy_o` out 1: high when in LOCKED or FIFO not empty; this replaces the old `data_avail`.
- `clip_cnt_o` out 16: saturating count of dropped pixels.

## Operation
- State machine with two states, IDLE and LOCKED, plus a round-robin pointer `rr_ptr`.
- In IDLE:
  - Search `src_valid_i` starting at `rr_ptr`, wrapping modulo `NUM_SRC`.
  - The first asserted source is latched as `owner`; the next state is LOCKED.
  - If no source is valid, remain in IDLE.
- In LOCKED:
  - `src_ready_o[owner]` = FIFO not full; every other ready bit is 0.
  - Transfer occurs when `src_valid_i[owner]` and `src_ready_o[owner]` are both high.
  - A transfer with `src_last_i[owner]` set moves to IDLE and sets `rr_ptr` = `owner`+1 modulo `NUM_SRC`.
- In IDLE, all `src_ready_o` bits are 0.
- Clipping (when enabled): a transferred pixel with x ≥ `SCREEN_W` or y ≥ `SCREEN_H` is consumed but not written to the FIFO. `clip_cnt_o` increments and saturates at 16'hFFFF. If the clipped pixel carried last, the lock still releases, but no `last_o` is emitted.
- FIFO:
  - Width X_BITS+Y_BITS+3*CH_BITS+1.
  - Depth `DEPTH`, first-word-fall-through.
  - Pop occurs when `pix_valid_o && pix_ready_i`.
  - Full = count==DEPTH; push is blocked by ready, so a write to a full FIFO never occurs.
  - Simultaneous push and pop leaves the count unchanged; pointers wrap at `DEPTH`.

## Timing
- Reset values:
  - State IDLE; `rr_ptr`, `owner`, and `clip_cnt_o` = 0.
  - FIFO empty, so `pix_valid_o`=0, `busy_o`=0, and `src_ready_o`=0.
  - Data outputs `x_o`, `y_o`, `r_o`, `g_o`, `b_o`, `last_o` = 0 while the FIFO is empty.
- Arbitration costs 1 cycle: source valid in IDLE at cycle n gives `src_ready_o` high at cycle n+1 at the earliest.
- Accept-to-output latency: a pixel accepted at edge n appears on `pix_valid_o` after edge n, i.e. in cycle n+1.
- Throughput is 1 pixel/cycle while LOCKED, the FIFO is not full, and `pix_ready_i` is high.
- Output data holds stable while `pix_valid_o && !pix_ready_i`.
- Asserting reset mid-operation drops buffered and partial primitives immediately; no output appears until a new grant.

## Configuration
- `GPU_CLIP_EN` defined: clipping is active as described in Operation.
- `GPU_CLIP_EN` undefined:
  - Every transferred pixel is written to the FIFO; coordinates pass through unmodified.
  - `clip_cnt_o` is tied to 0, and the compare logic is not synthesised.

## Structure
- Shared package `gpu_pkg`:
  - Default `X_BITS`/`Y_BITS`/`CH_BITS`/`SCREEN_W`/`SCREEN_H` constants, superseding the old WIDTH/HEIGHT/CHANNEL defines.
  - `arb_state_t` enum {IDLE, LOCKED}.
  - Packed `pixel_t` struct {x, y, r, g, b, last}.
- Sub-module `gpu_pixel_fifo`: parametrised FWFT FIFO with push/pop/full/empty/count, instantiated once.
- Arbiter FSM, clip compare and counter live in the top.

## Test plan
- NUM_SRC=2, engine 0 sends a 3-pixel primitive (0,0),(1,0),(2,0) with last on the third, `pix_ready_i`=1 → 3 outputs in order, `last_o` on (2,0), first output 2 cycles after valid is raised.
- Both engines valid at the same time from reset → engine 0's whole primitive precedes engine 1's; no interleave. The next contest goes to engine 1 first.
- Hold `pix_ready_i`=0 and push 10 pixels with DEPTH=8 → exactly 8 accepted, then `src_ready_o`=0. Release ready → all 8 drain in order, and the remaining 2 follow.
- `GPU_CLIP_EN`, pixels (639,479), (640,0), (0,480) → only (639,479) is output; `clip_cnt_o`=2.
- Clipped last pixel (700,5,last) → lock releases; no `last_o`; the next source is granted.
- Reset asserted with 4 pixels buffered → `pix_valid_o`=0 and `busy_o`=0 immediately; after release the FIFO is empty and the state is IDLE.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU pixel-path package: default geometry, arbiter states and
// the default-width pixel bundle.
package gpu_pkg;

   localparam int DEF_X_BITS   = 10;
   localparam int DEF_Y_BITS   = 9;
   localparam int DEF_CH_BITS  = 8;
   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_SCREEN_H = 480;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_t;

   typedef struct packed {
      logic [DEF_X_BITS-1:0]  x;
      logic [DEF_Y_BITS-1:0]  y;
      logic [DEF_CH_BITS-1:0] r;
      logic [DEF_CH_BITS-1:0] g;
      logic [DEF_CH_BITS-1:0] b;
      logic                   last;
   } pixel_t;

endpackage

// File: rtl/gpu_pixel_arbiter_if.sv
// Engine-side and memory-side pixel handshake bundle of the pixel
// arbiter; slave = arbiter, master = engines plus downstream.
interface gpu_pixel_arbiter_if
   import gpu_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int X_BITS  = DEF_X_BITS,
   parameter int Y_BITS  = DEF_Y_BITS,
   parameter int CH_BITS = DEF_CH_BITS
);

   logic [NUM_SRC-1:0]           src_valid_i;
   logic [NUM_SRC-1:0]           src_ready_o;
   logic [NUM_SRC-1:0]           src_last_i;
   logic [NUM_SRC*X_BITS-1:0]    src_x_i;
   logic [NUM_SRC*Y_BITS-1:0]    src_y_i;
   logic [NUM_SRC*3*CH_BITS-1:0] src_rgb_i;

   logic               pix_valid_o;
   logic               pix_ready_i;
   logic [X_BITS-1:0]  x_o;
   logic [Y_BITS-1:0]  y_o;
   logic [CH_BITS-1:0] r_o;
   logic [CH_BITS-1:0] g_o;
   logic [CH_BITS-1:0] b_o;
   logic               last_o;
   logic               busy_o;
   logic [15:0]        clip_cnt_o;

   modport slave (
      input  src_valid_i, src_last_i, src_x_i,
      input  src_y_i, src_rgb_i, pix_ready_i,
      output src_ready_o, pix_valid_o,
      output x_o, y_o, r_o, g_o, b_o,
      output last_o, busy_o, clip_cnt_o
   );

   modport master (
      output src_valid_i, src_last_i, src_x_i,
      output src_y_i, src_rgb_i, pix_ready_i,
      input  src_ready_o, pix_valid_o,
      input  x_o, y_o, r_o, g_o, b_o,
      input  last_o, busy_o, clip_cnt_o
   );

endinterface

// File: rtl/gpu_pixel_fifo.sv
// First-word-fall-through pixel FIFO; data reads as zero while empty.
module gpu_pixel_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/gpu_pixel_arbiter.sv
// Round-robin, primitive-locked merge of NUM_SRC engine pixel streams
// into one FIFO-buffered stream. Define GPU_CLIP_EN to drop off-screen pixels.
module gpu_pixel_arbiter
   import gpu_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 8,
   parameter int X_BITS   = DEF_X_BITS,
   parameter int Y_BITS   = DEF_Y_BITS,
   parameter int CH_BITS  = DEF_CH_BITS,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H
) (
   input logic                clk,
   input logic                n_rst,
   gpu_pixel_arbiter_if.slave bus
);

   localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int RGB = 3 * CH_BITS;
   localparam int AW  = $clog2(DEPTH);

   if (NUM_SRC < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_cfg
      $error("gpu_pixel_arbiter: illegal parameters");
   end

   typedef struct packed {
      logic [X_BITS-1:0]  x;
      logic [Y_BITS-1:0]  y;
      logic [CH_BITS-1:0] r;
      logic [CH_BITS-1:0] g;
      logic [CH_BITS-1:0] b;
      logic               last;
   } pix_t;

   arb_state_t    state;
   logic [SW-1:0] owner;
   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] pick;
   logic          pick_ok;

   logic              o_valid;
   logic              o_last;
   logic [X_BITS-1:0] o_x;
   logic [Y_BITS-1:0] o_y;
   logic [RGB-1:0]    o_rgb;

   logic        full;
   logic        empty;
   logic [AW:0] count;
   logic        xfer;
   logic        clip;
   logic        push;
   logic        pop;
   pix_t        wr;
   pix_t        rd;

   assign o_valid = bus.src_valid_i[owner];
   assign o_last  = bus.src_last_i[owner];
   assign o_x     = bus.src_x_i[int'(owner)*X_BITS +: X_BITS];
   assign o_y     = bus.src_y_i[int'(owner)*Y_BITS +: Y_BITS];
   assign o_rgb   = bus.src_rgb_i[int'(owner)*RGB +: RGB];

   // First valid engine at or after rr_ptr, wrapping around.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         int j;
         j = int'(rr_ptr) + i;
         if (j >= NUM_SRC) j = j - NUM_SRC;
         if (!pick_ok && bus.src_valid_i[SW'(j)]) begin
            pick_ok = 1'b1;
            pick    = SW'(j);
         end
      end
   end

   always_comb begin
      bus.src_ready_o = '0;
      if (state == LOCKED && !full) bus.src_ready_o[owner] = 1'b1;
   end

   assign xfer = (state == LOCKED) && o_valid && !full;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_ok) begin
                  owner <= pick;
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               if (xfer && o_last) begin
                  state  <= IDLE;
                  rr_ptr <= (owner == SW'(NUM_SRC - 1)) ? '0 : owner + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef GPU_CLIP_EN
   logic [15:0] clip_cnt;

   assign clip = (int'(o_x) >= SCREEN_W) || (int'(o_y) >= SCREEN_H);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         clip_cnt <= '0;
      end else if (xfer && clip && clip_cnt != 16'hFFFF) begin
         clip_cnt <= clip_cnt + 1'b1;
      end
   end

   assign bus.clip_cnt_o = clip_cnt;
`else
   assign clip           = 1'b0;
   assign bus.clip_cnt_o = '0;
`endif

   assign push = xfer && !clip;
   assign pop  = !empty && bus.pix_ready_i;
   assign wr   = {o_x, o_y, o_rgb, o_last};

   gpu_pixel_fifo #(
      .W     ($bits(pix_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (push),
      .din   (wr),
      .pop   (pop),
      .dout  (rd),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign bus.pix_valid_o = !empty;
   assign bus.x_o         = rd.x;
   assign bus.y_o         = rd.y;
   assign bus.r_o         = rd.r;
   assign bus.g_o         = rd.g;
   assign bus.b_o         = rd.b;
   assign bus.last_o      = rd.last;
   assign bus.busy_o      = (state == LOCKED) || (count != '0);

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// Randomized bench for gpu_pixel_arbiter with a primitive-level
// round-robin scoreboard model.
module tb_gpu_pixel_arbiter;
   import gpu_pkg::*;

   localparam int NS    = 2;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;

   always #5 clk = ~clk;

   gpu_pixel_arbiter_if #(.NUM_SRC(NS)) bus ();

   gpu_pixel_arbiter #(
      .NUM_SRC (NS),
      .DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int accepted = 0;
   int first_out;
   int last_out;
   int m_rr     = 0;
   int m_clip   = 0;

   pixel_t src_q [NS][$];
   pixel_t exp_q [$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit offscreen(input pixel_t p);
`ifdef GPU_CLIP_EN
      return (int'(p.x) >= DEF_SCREEN_W) || (int'(p.y) >= DEF_SCREEN_H);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [43:0] out_word();
      return {bus.x_o, bus.y_o, bus.r_o, bus.g_o, bus.b_o, bus.last_o};
   endfunction

   task automatic add_pix(input int k, input int x, input int y,
                          input bit last);
      pixel_t p;
      p.x    = 10'(x);
      p.y    = 9'(y);
      p.r    = 8'($urandom);
      p.g    = 8'($urandom);
      p.b    = 8'($urandom);
      p.last = last;
      src_q[k].push_back(p);
   endtask

   task automatic add_rand_prim(input int k, input int n);
      for (int i = 0; i < n; i++)
         add_pix(k, $urandom_range(0, 700), $urandom_range(0, 511),
                 i == n - 1);
   endtask

   // Whole primitives, engines taken round-robin among those with work.
   task automatic plan();
      pixel_t c [NS][$];
      bit     any;
      for (int k = 0; k < NS; k++) c[k] = src_q[k];
      forever begin
         int k;
         any = 1'b0;
         k   = m_rr;
         for (int i = 0; i < NS; i++) begin
            if (!any && c[(m_rr + i) % NS].size() > 0) begin
               any = 1'b1;
               k   = (m_rr + i) % NS;
            end
         end
         if (!any) break;
         forever begin
            pixel_t p;
            p = c[k].pop_front();
            if (offscreen(p)) begin
               if (m_clip < 16'hFFFF) m_clip++;
            end else begin
               exp_q.push_back(p);
            end
            if (p.last) break;
         end
         m_rr = (k + 1) % NS;
      end
   endtask

   task automatic drive(input int rdy_pct);
      for (int k = 0; k < NS; k++) begin
         if (src_q[k].size() > 0) begin
            bus.src_valid_i[k]          = 1'b1;
            bus.src_last_i[k]           = src_q[k][0].last;
            bus.src_x_i[k*10 +: 10]     = src_q[k][0].x;
            bus.src_y_i[k*9 +: 9]       = src_q[k][0].y;
            bus.src_rgb_i[k*24 +: 24]   = {src_q[k][0].r, src_q[k][0].g,
                                           src_q[k][0].b};
         end else begin
            bus.src_valid_i[k]          = 1'b0;
            bus.src_last_i[k]           = 1'($urandom);
            bus.src_x_i[k*10 +: 10]     = 10'($urandom);
            bus.src_y_i[k*9 +: 9]       = 9'($urandom);
            bus.src_rgb_i[k*24 +: 24]   = 24'($urandom);
         end
      end
      bus.pix_ready_i = $urandom_range(0, 99) < rdy_pct;
   endtask

   function automatic bit all_done();
      bit d;
      d = exp_q.size() == 0;
      for (int k = 0; k < NS; k++) if (src_q[k].size() > 0) d = 1'b0;
      return d;
   endfunction

   task automatic run(input int rdy_pct, input int ncyc, input bit until_done);
      logic [NS-1:0] hs;
      logic [43:0]   cur;
      logic [43:0]   prev;
      bit            stall;
      bit            fin;
      stall     = 1'b0;
      prev      = '0;
      fin       = 1'b0;
      first_out = -1;
      last_out  = -1;
      @(posedge clk);
      #1;
      drive(rdy_pct);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         chk("ready_onehot0", 64'($countones(bus.src_ready_o) <= 1), 1);
         cur = out_word();
         if (stall) chk("hold_stable", cur, prev);
         if (!bus.pix_valid_o) chk("empty_zero", cur, 0);
         if (bus.pix_valid_o && bus.pix_ready_i) begin
            if (first_out < 0) first_out = c;
            last_out = c;
            if (exp_q.size() == 0) chk("unexpected_pixel", 1, 0);
            else chk("pixel", cur, exp_q.pop_front());
         end
         stall = bus.pix_valid_o && !bus.pix_ready_i;
         prev  = cur;
         hs    = bus.src_valid_i & bus.src_ready_o;
         @(posedge clk);
         #1;
         for (int k = 0; k < NS; k++) begin
            if (hs[k]) begin
               void'(src_q[k].pop_front());
               accepted++;
            end
         end
         drive(rdy_pct);
         if (until_done && all_done()) begin
            fin = 1'b1;
            break;
         end
      end
      if (until_done) chk("timeout", fin, 1);
   endtask

   initial begin
      bus.src_valid_i = '0;
      bus.src_last_i  = '0;
      bus.src_x_i     = '0;
      bus.src_y_i     = '0;
      bus.src_rgb_i   = '0;
      bus.pix_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix_valid", bus.pix_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_src_ready", bus.src_ready_o, 0);
      chk("rst_data", out_word(), 0);
      chk("rst_clip_cnt", bus.clip_cnt_o, 0);
      n_rst = 1'b1;

      // Contest from reset: engine 0 first, then engine 1.
      add_rand_prim(0, 3);
      add_rand_prim(0, 2);
      add_rand_prim(1, 2);
      add_rand_prim(1, 1);
      plan();
      run(100, 200, 1);
      chk("contest_busy", bus.busy_o, 0);

      accepted = 0;
      add_pix(0, 0, 0, 0);
      add_pix(0, 1, 0, 0);
      add_pix(0, 2, 0, 1);
      plan();
      run(100, 50, 1);
      chk("first_latency", 64'(first_out), 2);
      chk("last_cycle", 64'(last_out), 4);
      chk("accepted3", 64'(accepted), 3);

      accepted = 0;
      for (int i = 0; i < 10; i++) add_pix(1, i, 3, i == 9);
      plan();
      run(0, 20, 0);
      chk("full_accepted", 64'(accepted), DEPTH);
      chk("full_ready", bus.src_ready_o, 0);
      chk("full_valid", bus.pix_valid_o, 1);
      chk("full_busy", bus.busy_o, 1);
      run(100, 200, 1);
      chk("drain_accepted", 64'(accepted), 10);

      add_pix(0, 639, 479, 0);
      add_pix(0, 640, 0, 0);
      add_pix(0, 0, 480, 1);
      add_pix(0, 700, 5, 1);
      add_pix(1, 7, 7, 1);
      add_pix(1, 8, 8, 1);
      plan();
      run(100, 200, 1);
      chk("clip_cnt", bus.clip_cnt_o, 64'(m_clip));
      chk("clip_busy", bus.busy_o, 0);

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < NS; k++)
            for (int p = $urandom_range(0, 3); p > 0; p--)
               add_rand_prim(k, $urandom_range(1, 5));
         plan();
         run(60, 2000, 1);
         chk("rand_clip_cnt", bus.clip_cnt_o, 64'(m_clip));
      end

      accepted = 0;
      add_rand_prim(0, 6);
      plan();
      run(0, 5, 0);
      chk("pre_rst_accepted", 64'(accepted), 4);
      chk("pre_rst_valid", bus.pix_valid_o, 1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("mid_rst_valid", bus.pix_valid_o, 0);
      chk("mid_rst_busy", bus.busy_o, 0);
      chk("mid_rst_ready", bus.src_ready_o, 0);
      for (int k = 0; k < NS; k++) src_q[k].delete();
      exp_q.delete();
      m_rr   = 0;
      m_clip = 0;
      drive(100);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", bus.pix_valid_o, 0);
      chk("post_rst_busy", bus.busy_o, 0);
      chk("post_rst_clip", bus.clip_cnt_o, 0);

      add_rand_prim(1, 2);
      add_rand_prim(0, 3);
      add_rand_prim(1, 1);
      plan();
      run(70, 300, 1);
      chk("final_busy", bus.busy_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
